// File: rtl/demultiplexer_1to4_pkg.sv
// Shared types and constants for the registered 1-to-4 demultiplexer.
package demultiplexer_1to4_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_CH0 = 2'd0;
  localparam sel_t SEL_CH1 = 2'd1;
  localparam sel_t SEL_CH2 = 2'd2;
  localparam sel_t SEL_CH3 = 2'd3;

  localparam logic [NUM_CH-1:0] SEL_OH_RST = 4'b0000;

endpackage

// File: rtl/demultiplexer_1to4_decoder.sv
// Combinational 2-bit select to one-hot decode; an unknown select yields X, never a channel.
module demux_decoder_2to4
  import demultiplexer_1to4_pkg::*;
(
  input  sel_t              sel,
  output logic [NUM_CH-1:0] oh
);

  always_comb begin
    oh = '0;
    case (sel)
      SEL_CH0: oh = 4'b0001;
      SEL_CH1: oh = 4'b0010;
      SEL_CH2: oh = 4'b0100;
      SEL_CH3: oh = 4'b1000;
      default: oh = 'x;
    endcase
  end

endmodule

// File: rtl/demultiplexer_1to4.sv
// Registered 1-to-4 demux: d steers to the selected channel, the others clear to zero.
module demultiplexer_1to4
  import demultiplexer_1to4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             s0,
  input  logic             s1,
  output logic [WIDTH-1:0] i0,
  output logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] i3,
  output logic [3:0]       sel_oh
);

  sel_t                          sel;
  logic [NUM_CH-1:0]             oh;
  logic [NUM_CH-1:0][WIDTH-1:0]  ch_d;
  logic [NUM_CH-1:0][WIDTH-1:0]  ch_q;
  logic [NUM_CH-1:0]             sel_oh_q;

  assign sel = {s1, s0};

  demux_decoder_2to4 u_dec (
    .sel (sel),
    .oh  (oh)
  );

  // Each channel is d gated by its replicated one-hot bit, so exclusivity falls out of the decode.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_d[g] = d & {WIDTH{oh[g]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q     <= '0;
      sel_oh_q <= SEL_OH_RST;
    end else if (en) begin
      ch_q     <= ch_d;
      sel_oh_q <= oh;
    end
  end

  assign i0     = ch_q[0];
  assign i1     = ch_q[1];
  assign i2     = ch_q[2];
  assign i3     = ch_q[3];
  assign sel_oh = sel_oh_q;

endmodule

// File: tb/tb_demultiplexer_1to4.sv
// Bench for demultiplexer_1to4: a WIDTH=1 and a WIDTH=8 instance share control inputs.
module tb_demultiplexer_1to4;

  logic       clk = 1'b0;
  logic       rst, en, s0, s1;
  logic       d1;
  logic [7:0] d8;
  logic       a_i0, a_i1, a_i2, a_i3;
  logic [7:0] b_i0, b_i1, b_i2, b_i3;
  logic [3:0] a_oh, b_oh;

  int errors = 0;
  int checks = 0;

  // Reference state: the value each channel should hold, plus the expected one-hot.
  logic       m1 [4];
  logic [7:0] m8 [4];
  logic [3:0] moh;

  always #5 clk = ~clk;

  demultiplexer_1to4 #(.WIDTH(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .d(d1), .s0(s0), .s1(s1),
    .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3), .sel_oh(a_oh)
  );

  demultiplexer_1to4 #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .d(d8), .s0(s0), .s1(s1),
    .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3), .sel_oh(b_oh)
  );

  function automatic logic [3:0] exp1();
    return {m1[3], m1[2], m1[1], m1[0]};
  endfunction

  function automatic logic [31:0] exp8();
    return {m8[3], m8[2], m8[1], m8[0]};
  endfunction

  // Advance one edge and apply the routing rules to the reference arrays.
  task automatic tick();
    int sel;
    @(posedge clk);
    sel = 2 * int'(s1) + int'(s0);
    if (rst) begin
      for (int c = 0; c < 4; c++) begin m1[c] = 1'b0; m8[c] = 8'h00; end
      moh = 4'b0000;
    end else if (en) begin
      for (int c = 0; c < 4; c++) begin
        m1[c] = (c == sel) ? d1 : 1'b0;
        m8[c] = (c == sel) ? d8 : 8'h00;
      end
      moh = 4'(1 << sel);
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] s,
                       input logic v1, input logic [7:0] v8);
    rst = r; en = e; {s1, s0} = s; d1 = v1; d8 = v8;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 2'b11, 1'b1, 8'hFF);
    tick(); tick();
    checks++;
    if ({a_i3, a_i2, a_i1, a_i0} !== 4'b0000 || a_oh !== 4'b0000) begin
      errors++;
      $display("FAIL reset_w1 outs=%b oh=%b want outs=0000 oh=0000", {a_i3, a_i2, a_i1, a_i0}, a_oh);
    end
    checks++;
    if ({b_i3, b_i2, b_i1, b_i0} !== 32'h0 || b_oh !== 4'b0000) begin
      errors++;
      $display("FAIL reset_w8 outs=%h oh=%b want outs=00000000 oh=0000", {b_i3, b_i2, b_i1, b_i0}, b_oh);
    end
  endtask

  task automatic test_sweep();
    logic [1:0] sels [4];
    logic [3:0] want_oh [4];
    logic [3:0] want_one [4];
    sels = '{2'b00, 2'b10, 2'b01, 2'b11};
    want_oh = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    want_one = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, sels[k/2], k[0], {7'b0, k[0]});
      tick();
      checks++;
      if ({a_i3, a_i2, a_i1, a_i0} !== (k[0] ? want_one[k/2] : 4'b0000) || a_oh !== want_oh[k/2]) begin
        errors++;
        $display("FAIL sweep s=%b d=%0d outs=%b oh=%b want outs=%b oh=%b", sels[k/2], k[0],
                 {a_i3, a_i2, a_i1, a_i0}, a_oh, k[0] ? want_one[k/2] : 4'b0000, want_oh[k/2]);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 2'b10, 1'b1, 8'h3C);
    tick();
    drive(1'b0, 1'b0, 2'b01, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({a_i3, a_i2, a_i1, a_i0} !== 4'b0100 || a_oh !== 4'b0100 || b_i2 !== 8'h3C) begin
        errors++;
        $display("FAIL hold cyc=%0d outs=%b oh=%b b_i2=%h want outs=0100 oh=0100 b_i2=3c", k,
                 {a_i3, a_i2, a_i1, a_i0}, a_oh, b_i2);
      end
    end
  endtask

  task automatic test_wide();
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 1'b1, 2'(s), 1'b0, 8'hA5);
      tick();
      checks++;
      if ({b_i3, b_i2, b_i1, b_i0} !== (32'hA5 << (8 * s)) || b_oh !== 4'(1 << s)) begin
        errors++;
        $display("FAIL wide s=%0d outs=%h oh=%b want outs=%h oh=%b", s, {b_i3, b_i2, b_i1, b_i0},
                 b_oh, 32'hA5 << (8 * s), 4'(1 << s));
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 1'b1, 2'b11, 1'b1, 8'h01);
    tick();
    checks++;
    if ({a_i3, a_i2, a_i1, a_i0} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_pre outs=%b want 1000", {a_i3, a_i2, a_i1, a_i0});
    end
    drive(1'b1, 1'b1, 2'b11, 1'b1, 8'h01);
    tick();
    checks++;
    if ({a_i3, a_i2, a_i1, a_i0} !== 4'b0000 || a_oh !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst outs=%b oh=%b want outs=0000 oh=0000", {a_i3, a_i2, a_i1, a_i0}, a_oh);
    end
    drive(1'b0, 1'b1, 2'b00, 1'b1, 8'h01);
    tick();
    checks++;
    if ({a_i3, a_i2, a_i1, a_i0} !== 4'b0001 || a_oh !== 4'b0001) begin
      errors++;
      $display("FAIL mid_post outs=%b oh=%b want outs=0001 oh=0001", {a_i3, a_i2, a_i1, a_i0}, a_oh);
    end
  endtask

  task automatic test_random();
    int nz;
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom), 8'($urandom));
      tick();
      checks++;
      if ({a_i3, a_i2, a_i1, a_i0} !== exp1() || {b_i3, b_i2, b_i1, b_i0} !== exp8()
          || a_oh !== moh || b_oh !== moh) begin
        errors++;
        $display("FAIL random k=%0d a=%b b=%h oh=%b/%b want a=%b b=%h oh=%b", k,
                 {a_i3, a_i2, a_i1, a_i0}, {b_i3, b_i2, b_i1, b_i0}, a_oh, b_oh, exp1(), exp8(), moh);
      end
      nz = int'(b_i0 != 0) + int'(b_i1 != 0) + int'(b_i2 != 0) + int'(b_i3 != 0);
      checks++;
      if (nz > 1) begin
        errors++;
        $display("FAIL exclusive k=%0d nonzero=%0d want <=1", k, nz);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin m1[c] = 1'b0; m8[c] = 8'h00; end
    moh = 4'b0000;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    test_reset();
    test_sweep();
    test_hold();
    test_wide();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
